// File: rtl/sio_dmu_tx.sv
// sio_dmu_tx: SIU-to-DMU transmit engine with packet FIFO, DMU header credits and per-lane parity
module sio_dmu_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic         iol2clk,
    input  logic         rst_l,
    input  logic         pkt_vld,
    output logic         pkt_rdy,
    input  logic [127:0] pkt_hdr,
    input  logic         pkt_has_data,
    input  logic [511:0] pkt_data,
    input  logic         dmu_sio_credit,
    output logic         sio_dmu_hdr_vld,
    output logic         sio_dmu_datareq,
    output logic [127:0] sio_dmu_data,
    output logic [7:0]   sio_dmu_parity,
    output logic         tx_busy,
    output logic         err_credit_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    typedef enum logic {IDLE, PAYLOAD} state_t;
    state_t        state;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [640:0]  mem [FIFO_DEPTH];
    logic [640:0]  head;
    logic [511:0]  cur_data;
    logic [1:0]    beat;
    logic [CW-1:0] credits;
    logic          empty, full, push, pop;
    logic [127:0]  data_d;
    logic [7:0]    par_d;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pkt_rdy = !full;
    assign push    = pkt_vld && !full;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign pop     = state == IDLE && !empty && credits != '0;
    assign tx_busy = !empty || state != IDLE;
    always_comb begin
        data_d = pop ? head[640:513] : state == PAYLOAD ? cur_data[{beat, 7'd0} +: 128] : '0;
        par_d  = '0;
        for (int i = 0; i < 8; i++) par_d[i] = ^data_d[16*i +: 16];
    end
    always_ff @(posedge iol2clk) if (push) mem[wr_ptr[AW-1:0]] <= {pkt_hdr, pkt_has_data, pkt_data};
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            beat            <= '0;
            cur_data        <= '0;
            credits         <= CW'(CREDITS);
            err_credit_ovf  <= 1'b0;
            sio_dmu_hdr_vld <= 1'b0;
            sio_dmu_datareq <= 1'b0;
            sio_dmu_data    <= '0;
            sio_dmu_parity  <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
            if (dmu_sio_credit && !pop && credits == CW'(CREDITS)) err_credit_ovf <= 1'b1;
            else if (dmu_sio_credit && !pop) credits <= credits + 1'b1;
            else if (pop && !dmu_sio_credit) credits <= credits - 1'b1;
            sio_dmu_hdr_vld <= pop;
            sio_dmu_datareq <= pop && head[512];
            sio_dmu_data    <= data_d;
            sio_dmu_parity  <= par_d;
            if (state == PAYLOAD) begin
                beat <= beat + 1'b1;
                if (beat == 2'd3) state <= IDLE;
            end else if (pop && head[512]) begin
                state    <= PAYLOAD;
                beat     <= '0;
                cur_data <= head[511:0];
            end
        end
    end
endmodule
